// File: rtl/midi_msg_parser.sv
// MIDI channel-voice parser for the monophonic voice path.
// Tracks status and running status, filters on channel, drives note/gate/bend.
module midi_msg_parser #(
    parameter int CHANNEL = 0,
    parameter bit OMNI    = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic [6:0]  o_note,
    output logic [6:0]  o_velocity,
    output logic        o_note_on,
    output logic        o_note_off,
    output logic        o_gate,
    output logic [13:0] o_bend
);

    typedef enum logic [1:0] {IDLE, D1, D2, SYSEX} state_t;

    localparam logic [3:0] CH = CHANNEL[3:0];

    state_t      state_q;
    logic [3:0]  type_q;
    logic        match_q;
    logic [6:0]  d1_q;
    logic [6:0]  note_q;
    logic [6:0]  vel_q;
    logic        on_q;
    logic        off_q;
    logic        gate_q;
    logic [13:0] bend_q;

    logic       is_data;
    logic       is_chan;
    logic       is_sys;
    logic       is_rt;
    logic       two_byte;
    logic       done;
    logic       fire;
    logic [6:0] m_d1;
    logic [6:0] m_d2;
    logic       on_d;
    logic       off_d;
    logic       bend_ld;

    // Classify the byte and decide whether it completes a message with an effect.
    always_comb begin
        is_data  = ~i_byte[7];
        is_rt    = &i_byte[7:3];
        is_sys   = (i_byte[7:3] == 5'b11110);
        is_chan  = i_byte[7] && (i_byte[7:4] != 4'hF);
        two_byte = (type_q != 4'hC) && (type_q != 4'hD);
        done     = i_byte_valid && is_data &&
                   (((state_q == D1) && !two_byte) || (state_q == D2));
        fire     = done && match_q;
        m_d1     = (state_q == D2) ? d1_q : i_byte[6:0];
        m_d2     = i_byte[6:0];
        on_d     = fire && (type_q == 4'h9) && (m_d2 != 7'd0);
        off_d    = fire && gate_q &&
                   ((((type_q == 4'h8) ||
                      ((type_q == 4'h9) && (m_d2 == 7'd0))) &&
                     (m_d1 == note_q)) ||
                    ((type_q == 4'hB) && (m_d1 == 7'd123)));
        bend_ld  = fire && (type_q == 4'hE);
    end

    // Message FSM with registered note, gate, strobe and bend outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            type_q  <= 4'h0;
            match_q <= 1'b0;
            d1_q    <= 7'd0;
            note_q  <= 7'd0;
            vel_q   <= 7'd0;
            on_q    <= 1'b0;
            off_q   <= 1'b0;
            gate_q  <= 1'b0;
            bend_q  <= 14'h2000;
        end else begin
            on_q  <= on_d;
            off_q <= off_d;
            if (on_d) begin
                note_q <= m_d1;
                vel_q  <= m_d2;
                gate_q <= 1'b1;
            end
            if (off_d) begin
                gate_q <= 1'b0;
            end
            if (bend_ld) begin
                bend_q <= {m_d2, m_d1};
            end
            if (i_byte_valid) begin
                unique case (1'b1)
                    is_chan: begin
                        type_q  <= i_byte[7:4];
                        match_q <= OMNI || (i_byte[3:0] == CH);
                        state_q <= D1;
                    end
                    is_sys: begin
                        state_q <= (i_byte == 8'hF0) ? SYSEX : IDLE;
                    end
                    is_data: begin
                        case (state_q)
                            D1: begin
                                d1_q    <= i_byte[6:0];
                                state_q <= two_byte ? D2 : D1;
                            end
                            D2: state_q <= D1;
                            default: ;
                        endcase
                    end
                    is_rt: ;
                endcase
            end
        end
    end

    assign o_note     = note_q;
    assign o_velocity = vel_q;
    assign o_note_on  = on_q;
    assign o_note_off = off_q;
    assign o_gate     = gate_q;
    assign o_bend     = bend_q;

endmodule
